// File: rtl/arb_stream_mux_if.sv
// Bundle of the stream, output and arbiter handshake signals around arb_stream_mux.
// The mux connects through the slave modport; the environment uses master.
interface arb_stream_mux_if #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int SEL_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORTS*DATA_WIDTH-1:0] s_data;
  logic [PORTS-1:0]            s_valid;
  logic [PORTS-1:0]            s_last;
  logic [PORTS-1:0]            s_ready;
  logic [DATA_WIDTH-1:0]       m_data;
  logic                        m_valid;
  logic                        m_last;
  logic                        m_ready;
  logic [PORTS-1:0]            arb_request;
  logic [PORTS-1:0]            arb_acknowledge;
  logic [PORTS-1:0]            arb_grant;
  logic                        arb_grant_valid;
  logic [SEL_W-1:0]            arb_grant_encoded;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    input  arb_grant, arb_grant_valid, arb_grant_encoded,
    output s_ready, m_data, m_valid, m_last,
    output arb_request, arb_acknowledge
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    output arb_grant, arb_grant_valid, arb_grant_encoded,
    input  s_ready, m_data, m_valid, m_last,
    input  arb_request, arb_acknowledge
  );
endinterface

// File: rtl/arb_stream_mux.sv
// Frame-level stream mux behind an external arbiter: forwards the granted port's
// beats through a 2-entry skid buffer and releases the grant on the last-beat handshake.
module arb_stream_mux #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  arb_stream_mux_if.slave   bus,
  output logic              busy
);

  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
  logic                  head_last_q, head_last_d;
  logic                  tail_last_q, tail_last_d;
  logic [1:0]            occ_q, occ_d;
  logic                  ready_int_q, ready_int_d;
  logic                  frame_active_q, frame_active_d;

  logic [PORTS-1:0]      s_ready_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_WIDTH-1:0] in_data_s;
  logic                  in_last_s;

  // s_ready comes only from a register and the grant, so m_ready never reaches it combinationally
  assign s_ready_s            = {PORTS{ready_int_q & bus.arb_grant_valid}} & bus.arb_grant;
  assign bus.s_ready          = s_ready_s;
  assign bus.arb_request      = bus.s_valid;
  assign bus.arb_acknowledge  = bus.arb_grant & bus.s_valid & s_ready_s & bus.s_last;
  assign push_s               = |(bus.s_valid & s_ready_s);
  assign pop_s                = (occ_q != 2'd0) & bus.m_ready;
  assign bus.m_valid          = (occ_q != 2'd0);
  assign bus.m_data           = head_data_q;
  assign bus.m_last           = head_last_q;
  assign busy                 = frame_active_q | (occ_q != 2'd0);

  // Select the granted port's beat
  always_comb begin
    in_data_s = bus.s_data[int'(bus.arb_grant_encoded)*DATA_WIDTH +: DATA_WIDTH];
    in_last_s = bus.s_last[bus.arb_grant_encoded];
  end

  // Skid buffer next state: head is the output entry, tail holds the second beat
  always_comb begin
    head_data_d    = head_data_q;
    head_last_d    = head_last_q;
    tail_data_d    = tail_data_q;
    tail_last_d    = tail_last_q;
    occ_d          = occ_q;
    frame_active_d = frame_active_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_data_d = in_data_s;
          head_last_d = in_last_s;
        end else begin
          tail_data_d = in_data_s;
          tail_last_d = in_last_s;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
        occ_d       = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          tail_data_d = in_data_s;
          tail_last_d = in_last_s;
        end else begin
          head_data_d = in_data_s;
          head_last_d = in_last_s;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
    if (push_s) begin
      frame_active_d = ~in_last_s;
    end else begin
      frame_active_d = frame_active_q;
    end
    ready_int_d = (occ_d != 2'd2);
  end

  // State registers; reset drops any held beats and any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_q    <= '0;
      head_last_q    <= 1'b0;
      tail_data_q    <= '0;
      tail_last_q    <= 1'b0;
      occ_q          <= 2'd0;
      ready_int_q    <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      head_data_q    <= head_data_d;
      head_last_q    <= head_last_d;
      tail_data_q    <= tail_data_d;
      tail_last_q    <= tail_last_d;
      occ_q          <= occ_d;
      ready_int_q    <= ready_int_d;
      frame_active_q <= frame_active_d;
    end
  end

endmodule

// File: tb/tb_arb_stream_mux.sv
// Directed bench for arb_stream_mux with a small hold-until-acknowledge arbiter
// (lowest index wins, one idle cycle after each release).
module tb_arb_stream_mux;
  localparam int PORTS = 4;
  localparam int DW    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  arb_stream_mux_if #(.PORTS(PORTS), .DATA_WIDTH(DW)) bus ();

  arb_stream_mux #(.PORTS(PORTS), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Arbiter model: grant held until the acknowledge for the granted port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.arb_grant         <= 4'b0000;
      bus.arb_grant_valid   <= 1'b0;
      bus.arb_grant_encoded <= 2'd0;
    end else if (bus.arb_grant_valid) begin
      if (|(bus.arb_acknowledge & bus.arb_grant)) begin
        bus.arb_grant       <= 4'b0000;
        bus.arb_grant_valid <= 1'b0;
      end
    end else begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (bus.s_valid[i]) begin
          bus.arb_grant         <= 4'(1 << i);
          bus.arb_grant_encoded <= 2'(i);
          bus.arb_grant_valid   <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setd(input int p, input logic [7:0] d);
    bus.s_data[p*DW +: DW] = d;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l);
    chk({tag, ".m_valid"}, 32'(bus.m_valid), 32'(v));
    chk({tag, ".m_data"},  32'(bus.m_data),  32'(d));
    chk({tag, ".m_last"},  32'(bus.m_last),  32'(l));
  endtask

  initial begin
    bus.s_valid = 4'b0000;
    bus.s_last  = 4'b0000;
    bus.s_data  = 32'h0;
    bus.m_ready = 1'b0;

    // 1: reset state, then release
    step(); #1;
    chk_out("rst", 1'b0, 8'h00, 1'b0);
    chk("rst.s_ready", 32'(bus.s_ready), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk("rst.arb_request", 32'(bus.arb_request), 32'h0);
    rst_n = 1'b1;
    step(); #1;
    chk("idle.s_ready", 32'(bus.s_ready), 32'h0);
    chk("idle.m_valid", 32'(bus.m_valid), 32'h0);
    chk("idle.arb_request", 32'(bus.arb_request), 32'h0);

    // 2: port 2 three-beat frame, m_ready high
    bus.m_ready = 1'b1;
    step(); bus.s_valid = 4'b0100; setd(2, 8'h11); #1;
    chk("t2.arb_request", 32'(bus.arb_request), 32'h4);
    chk("t2.s_ready_pre", 32'(bus.s_ready), 32'h0);
    step(); #1;
    chk("t2.s_ready", 32'(bus.s_ready), 32'h4);
    chk("t2.ack0", 32'(bus.arb_acknowledge), 32'h0);
    step(); setd(2, 8'h22); #1;
    chk_out("t2.b0", 1'b1, 8'h11, 1'b0);
    chk("t2.busy", 32'(busy), 32'h1);
    step(); setd(2, 8'h33); bus.s_last = 4'b0100; #1;
    chk_out("t2.b1", 1'b1, 8'h22, 1'b0);
    chk("t2.ack_last", 32'(bus.arb_acknowledge), 32'h4);
    step(); bus.s_valid = 4'b0000; bus.s_last = 4'b0000; #1;
    chk_out("t2.b2", 1'b1, 8'h33, 1'b1);
    chk("t2.ack_after", 32'(bus.arb_acknowledge), 32'h0);
    chk("t2.s_ready_rel", 32'(bus.s_ready), 32'h0);
    step(); #1;
    chk("t2.drained", 32'(bus.m_valid), 32'h0);
    chk("t2.busy_end", 32'(busy), 32'h0);

    // 3: ports 0 and 1 race with two-beat frames; no interleave
    step(); bus.s_valid = 4'b0011; setd(0, 8'hA1); setd(1, 8'hB1); #1;
    step(); #1;
    chk("t3.s_ready_p0", 32'(bus.s_ready), 32'h1);
    step(); setd(0, 8'hA2); bus.s_last = 4'b0001; #1;
    chk_out("t3.a1", 1'b1, 8'hA1, 1'b0);
    chk("t3.ack_p0", 32'(bus.arb_acknowledge), 32'h1);
    step(); bus.s_valid = 4'b0010; bus.s_last = 4'b0000; #1;
    chk_out("t3.a2", 1'b1, 8'hA2, 1'b1);
    chk("t3.s_ready_gap", 32'(bus.s_ready), 32'h0);
    step(); #1;
    chk("t3.m_valid_gap", 32'(bus.m_valid), 32'h0);
    chk("t3.s_ready_p1", 32'(bus.s_ready), 32'h2);
    step(); setd(1, 8'hB2); bus.s_last = 4'b0010; #1;
    chk_out("t3.b1", 1'b1, 8'hB1, 1'b0);
    chk("t3.ack_p1", 32'(bus.arb_acknowledge), 32'h2);
    step(); bus.s_valid = 4'b0000; bus.s_last = 4'b0000; #1;
    chk_out("t3.b2", 1'b1, 8'hB2, 1'b1);
    step(); #1;
    chk("t3.drained", 32'(bus.m_valid), 32'h0);

    // 4: output stall for 5 cycles mid-frame on port 1
    step(); bus.s_valid = 4'b0010; setd(1, 8'hC1); #1;
    step(); #1;
    chk("t4.s_ready", 32'(bus.s_ready), 32'h2);
    step(); setd(1, 8'hC2); bus.m_ready = 1'b0; #1;
    chk_out("t4.c1", 1'b1, 8'hC1, 1'b0);
    chk("t4.s_ready_c2", 32'(bus.s_ready), 32'h2);
    for (int k = 0; k < 4; k++) begin
      step(); setd(1, 8'hC3); #1;
      chk_out("t4.hold", 1'b1, 8'hC1, 1'b0);
      chk("t4.full_s_ready", 32'(bus.s_ready), 32'h0);
      chk("t4.busy", 32'(busy), 32'h1);
    end
    step(); bus.m_ready = 1'b1; #1;
    chk_out("t4.c1_pop", 1'b1, 8'hC1, 1'b0);
    chk("t4.s_ready_pop", 32'(bus.s_ready), 32'h0);
    step(); #1;
    chk_out("t4.c2", 1'b1, 8'hC2, 1'b0);
    chk("t4.s_ready_back", 32'(bus.s_ready), 32'h2);
    step(); setd(1, 8'hC4); bus.s_last = 4'b0010; #1;
    chk_out("t4.c3", 1'b1, 8'hC3, 1'b0);
    chk("t4.ack", 32'(bus.arb_acknowledge), 32'h2);
    step(); bus.s_valid = 4'b0000; bus.s_last = 4'b0000; #1;
    chk_out("t4.c4", 1'b1, 8'hC4, 1'b1);
    step(); #1;
    chk("t4.drained", 32'(bus.m_valid), 32'h0);
    chk("t4.busy_end", 32'(busy), 32'h0);

    // 5: repeated single-beat frames on port 3
    step(); bus.s_valid = 4'b1000; bus.s_last = 4'b1000; setd(3, 8'hA0); #1;
    chk("t5.s_ready_pre", 32'(bus.s_ready), 32'h0);
    step(); #1;
    chk("t5.s_ready", 32'(bus.s_ready), 32'h8);
    chk("t5.ack0", 32'(bus.arb_acknowledge), 32'h8);
    step(); #1;
    chk_out("t5.f0", 1'b1, 8'hA0, 1'b1);
    chk("t5.ack_gap", 32'(bus.arb_acknowledge), 32'h0);
    step(); #1;
    chk("t5.m_valid_gap", 32'(bus.m_valid), 32'h0);
    chk("t5.ack1", 32'(bus.arb_acknowledge), 32'h8);
    step(); #1;
    chk_out("t5.f1", 1'b1, 8'hA0, 1'b1);
    bus.s_valid = 4'b0000; bus.s_last = 4'b0000;
    step(); #1;
    chk("t5.busy_end", 32'(busy), 32'h0);
    chk("t5.drained", 32'(bus.m_valid), 32'h0);

    // 6: reset mid-frame with a full buffer, then a clean frame
    bus.m_ready = 1'b0;
    step(); bus.s_valid = 4'b0001; setd(0, 8'hD1); #1;
    step(); #1;
    chk("t6.s_ready", 32'(bus.s_ready), 32'h1);
    step(); setd(0, 8'hD2); #1;
    step(); #1;
    chk("t6.full_s_ready", 32'(bus.s_ready), 32'h0);
    chk_out("t6.full", 1'b1, 8'hD1, 1'b0);
    rst_n = 1'b0; #1;
    chk_out("t6.rst", 1'b0, 8'h00, 1'b0);
    chk("t6.rst_s_ready", 32'(bus.s_ready), 32'h0);
    chk("t6.rst_busy", 32'(busy), 32'h0);
    bus.s_valid = 4'b0000;
    step(); rst_n = 1'b1; bus.m_ready = 1'b1;
    step(); bus.s_valid = 4'b0001; setd(0, 8'hE1); #1;
    chk("t6.no_resume", 32'(bus.m_valid), 32'h0);
    step(); #1;
    chk("t6.s_ready_new", 32'(bus.s_ready), 32'h1);
    step(); setd(0, 8'hE2); bus.s_last = 4'b0001; #1;
    chk_out("t6.e1", 1'b1, 8'hE1, 1'b0);
    chk("t6.ack", 32'(bus.arb_acknowledge), 32'h1);
    step(); bus.s_valid = 4'b0000; bus.s_last = 4'b0000; #1;
    chk_out("t6.e2", 1'b1, 8'hE2, 1'b1);
    step(); #1;
    chk("t6.drained", 32'(bus.m_valid), 32'h0);
    chk("t6.busy_end", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
